// File: rtl/charge_accum_pkg.sv
// Shared types and defaults for the charge RAM read-modify-write front end.
// The UCASPIAN_ACCUM_SAT_EN macro selects saturating accumulation; see charge_sat_add.
package ucaspian_pkg;

  typedef logic signed [15:0] charge_t;
  typedef logic signed [7:0]  weight_t;
  typedef logic        [7:0]  neuron_addr_t;

  localparam charge_t THRESHOLD_DEFAULT = 16'sd256;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    CLEAR
  } accum_state_e;

endpackage

// File: rtl/charge_accum_if.sv
// Event input, spike output, clear control and charge RAM port for charge_accum.
// slave is the accumulator's view; master is the surrounding system/RAM.
interface charge_accum_if #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 16,
  parameter int WEIGHT_W = 8
);
  logic                       clear_start;
  logic                       clear_busy;
  logic                       in_valid;
  logic                       in_ready;
  logic        [ADDR_W-1:0]   in_addr;
  logic signed [WEIGHT_W-1:0] in_weight;
  logic                       spk_valid;
  logic                       spk_ready;
  logic        [ADDR_W-1:0]   spk_addr;
  logic        [ADDR_W-1:0]   rd_addr;
  logic                       rd_en;
  logic signed [DATA_W-1:0]   rd_data;
  logic        [ADDR_W-1:0]   wr_addr;
  logic                       wr_en;
  logic signed [DATA_W-1:0]   wr_data;

  modport slave (
    input  clear_start, in_valid, in_addr, in_weight, spk_ready, rd_data,
    output clear_busy, in_ready, spk_valid, spk_addr, rd_addr, rd_en,
           wr_addr, wr_en, wr_data
  );

  modport master (
    output clear_start, in_valid, in_addr, in_weight, spk_ready, rd_data,
    input  clear_busy, in_ready, spk_valid, spk_addr, rd_addr, rd_en,
           wr_addr, wr_en, wr_data
  );
endinterface

// File: rtl/charge_accum_sat_add.sv
// Combinational charge + weight with threshold compare; shared with the leak path.
// UCASPIAN_ACCUM_SAT_EN clamps the result to the charge range, otherwise it wraps.
module charge_sat_add #(
  parameter int                       DATA_W    = 16,
  parameter int                       WEIGHT_W  = 8,
  parameter logic signed [DATA_W-1:0] THRESHOLD = 16'sd256
) (
  input  logic signed [DATA_W-1:0]   base,
  input  logic signed [WEIGHT_W-1:0] weight,
  output logic signed [DATA_W-1:0]   result,
  output logic                       fire
);

  logic signed [DATA_W:0] sum;

`ifdef UCASPIAN_ACCUM_SAT_EN
  localparam logic signed [DATA_W-1:0] MAX_C = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] MIN_C = {1'b1, {(DATA_W-1){1'b0}}};
`endif

  always_comb begin
    sum = {base[DATA_W-1], base}
        + {{(DATA_W+1-WEIGHT_W){weight[WEIGHT_W-1]}}, weight};
    result = sum[DATA_W-1:0];
`ifdef UCASPIAN_ACCUM_SAT_EN
    // top two bits disagree only when the true sum left the DATA_W range
    if (sum[DATA_W] != sum[DATA_W-1]) begin
      result = sum[DATA_W] ? MIN_C : MAX_C;
    end
`endif
    fire = (result >= THRESHOLD);
  end

endmodule

// File: rtl/charge_accum.sv
// Read-modify-write front end for the charge RAM: accumulates synaptic weights, fires
// spikes at threshold and sweeps the array to zero on request (UCASPIAN_ACCUM_SAT_EN in adder).
module charge_accum
  import ucaspian_pkg::*;
#(
  parameter int                       ADDR_W    = 8,
  parameter int                       DATA_W    = 16,
  parameter int                       WEIGHT_W  = 8,
  parameter logic signed [DATA_W-1:0] THRESHOLD = THRESHOLD_DEFAULT
) (
  input  logic           clk,
  input  logic           reset_n,
  charge_accum_if.slave  bus
);

  accum_state_e               state_q, state_d;
  logic        [ADDR_W-1:0]   cnt_q, cnt_d;
  logic                       b_valid_q, b_valid_d;
  logic        [ADDR_W-1:0]   b_addr_q, b_addr_d;
  logic signed [WEIGHT_W-1:0] b_weight_q, b_weight_d;
  logic                       b_held_q, b_held_d;
  logic signed [DATA_W-1:0]   b_base_q, b_base_d;
  logic                       fwd_valid_q, fwd_valid_d;
  logic        [ADDR_W-1:0]   fwd_addr_q, fwd_addr_d;
  logic signed [DATA_W-1:0]   fwd_data_q, fwd_data_d;
  logic                       spk_valid_q, spk_valid_d;
  logic        [ADDR_W-1:0]   spk_addr_q, spk_addr_d;

  logic signed [DATA_W-1:0]   base;
  logic signed [DATA_W-1:0]   result;
  logic                       fire_raw;
  logic                       fire;
  logic                       fwd_hit;
  logic                       b_done;
  logic                       b_write;
  logic                       accept;
  logic                       clearing;
  logic                       in_ready;
  logic                       wr_en;
  logic        [ADDR_W-1:0]   wr_addr;
  logic signed [DATA_W-1:0]   wr_data;

  charge_sat_add #(
    .DATA_W    (DATA_W),
    .WEIGHT_W  (WEIGHT_W),
    .THRESHOLD (THRESHOLD)
  ) u_add (
    .base   (base),
    .weight (b_weight_q),
    .result (result),
    .fire   (fire_raw)
  );

  always_comb begin
    clearing = (state_q == CLEAR);
    fwd_hit  = fwd_valid_q && (fwd_addr_q == b_addr_q);
    // a stalled event keeps the base it first saw; rd_data/fwd may move on meanwhile
    if (b_held_q) begin
      base = b_base_q;
    end else if (fwd_hit) begin
      base = fwd_data_q;
    end else begin
      base = bus.rd_data;
    end
    fire     = b_valid_q && fire_raw;
    b_done   = !fire || !spk_valid_q || bus.spk_ready;
    b_write  = b_valid_q && b_done;
    in_ready = (state_q == RUN) && !bus.clear_start && (!b_valid_q || b_done);
    accept   = bus.in_valid && in_ready;

    wr_en   = b_write || clearing;
    wr_addr = clearing ? cnt_q : b_addr_q;
    wr_data = (b_write && !clearing && !fire) ? result : '0;

    b_valid_d  = accept || (b_valid_q && !b_done);
    b_addr_d   = accept ? bus.in_addr   : b_addr_q;
    b_weight_d = accept ? bus.in_weight : b_weight_q;
    b_held_d   = b_valid_q && !b_done;
    b_base_d   = b_held_d ? base : b_base_q;

    fwd_valid_d = wr_en;
    fwd_addr_d  = wr_addr;
    fwd_data_d  = wr_data;

    spk_valid_d = spk_valid_q;
    spk_addr_d  = spk_addr_q;
    if (b_write && fire) begin
      spk_valid_d = 1'b1;
      spk_addr_d  = b_addr_q;
    end else if (bus.spk_ready) begin
      spk_valid_d = 1'b0;
    end

    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE:  state_d = RUN;
      RUN:   if (bus.clear_start) state_d = DRAIN;
      DRAIN: begin
        if (!b_valid_q) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        cnt_d = cnt_q + ADDR_W'(1);
        if (cnt_q == {ADDR_W{1'b1}}) state_d = RUN;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      b_valid_q   <= 1'b0;
      b_addr_q    <= '0;
      b_weight_q  <= '0;
      b_held_q    <= 1'b0;
      b_base_q    <= '0;
      fwd_valid_q <= 1'b0;
      fwd_addr_q  <= '0;
      fwd_data_q  <= '0;
      spk_valid_q <= 1'b0;
      spk_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      b_valid_q   <= b_valid_d;
      b_addr_q    <= b_addr_d;
      b_weight_q  <= b_weight_d;
      b_held_q    <= b_held_d;
      b_base_q    <= b_base_d;
      fwd_valid_q <= fwd_valid_d;
      fwd_addr_q  <= fwd_addr_d;
      fwd_data_q  <= fwd_data_d;
      spk_valid_q <= spk_valid_d;
      spk_addr_q  <= spk_addr_d;
    end
  end

  assign bus.clear_busy = (state_q == DRAIN) || (state_q == CLEAR);
  assign bus.in_ready   = in_ready;
  assign bus.rd_en      = accept;
  assign bus.rd_addr    = accept ? bus.in_addr : '0;
  assign bus.wr_en      = wr_en;
  assign bus.wr_addr    = wr_addr;
  assign bus.wr_data    = wr_data;
  assign bus.spk_valid  = spk_valid_q;
  assign bus.spk_addr   = spk_addr_q;

endmodule

// File: tb/tb_charge_accum.sv
// Directed bench for charge_accum: a default-threshold instance for the main function
// and a threshold-32767 instance for the overflow case (honours UCASPIAN_ACCUM_SAT_EN).
module tb_charge_accum;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  charge_accum_if #(.ADDR_W(8), .DATA_W(16), .WEIGHT_W(8)) ifm ();
  charge_accum_if #(.ADDR_W(8), .DATA_W(16), .WEIGHT_W(8)) hif ();

  charge_accum #(.ADDR_W(8), .DATA_W(16), .WEIGHT_W(8), .THRESHOLD(16'sd256)) u_dut (
    .clk(clk), .reset_n(reset_n), .bus(ifm));
  charge_accum #(.ADDR_W(8), .DATA_W(16), .WEIGHT_W(8), .THRESHOLD(16'sd32767)) u_hi (
    .clk(clk), .reset_n(reset_n), .bus(hif));

  logic signed [15:0] mem_m [256];
  logic signed [15:0] mem_h [256];
  logic preset_m = 1'b0;
  int   wr_cnt_m = 0;

  always @(posedge clk) begin
    if (preset_m) begin
      for (int i = 0; i < 256; i++) mem_m[i] <= 16'sh1234;
    end else if (ifm.wr_en) begin
      mem_m[ifm.wr_addr] <= ifm.wr_data;
    end
    if (ifm.rd_en) ifm.rd_data <= mem_m[ifm.rd_addr];
    if (ifm.wr_en) wr_cnt_m = wr_cnt_m + 1;
  end

  always @(posedge clk) begin
    if (hif.wr_en) mem_h[hif.wr_addr] <= hif.wr_data;
    if (hif.rd_en) hif.rd_data <= mem_h[hif.rd_addr];
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0] addr;
    int         w;
    int         exp_wr;
    logic       fire;
  } vec_t;

  vec_t vecs[15];

  task automatic send_m(input vec_t v);
    ifm.in_valid  = 1'b1;
    ifm.in_addr   = v.addr;
    ifm.in_weight = 8'(v.w);
    @(negedge clk);
    check("in_ready", int'(ifm.in_ready), 1);
    check("rd_addr", int'(ifm.rd_addr), int'(v.addr));
    @(posedge clk); #1;
    ifm.in_valid = 1'b0;
    @(negedge clk);
    check("wr_en", int'(ifm.wr_en), 1);
    check("wr_addr", int'(ifm.wr_addr), int'(v.addr));
    check("wr_data", int'(ifm.wr_data), v.exp_wr);
    @(posedge clk); #1;
    check("spk_valid", int'(ifm.spk_valid), int'(v.fire));
    if (v.fire) check("spk_addr", int'(ifm.spk_addr), int'(v.addr));
    @(posedge clk); #1;
    check("spk_drop", int'(ifm.spk_valid), 0);
  endtask

  initial begin
    int busy_cnt;
    int wr_seen;
    int nonzero;
    int snap;
    logic hit;
    logic stall_miss;

    vecs[0]  = '{8'd5,  100,  100,  1'b0};
    vecs[1]  = '{8'd5,  100,  200,  1'b0};
    vecs[2]  = '{8'd5,  100,  0,    1'b1};
    vecs[3]  = '{8'd5,  -128, -128, 1'b0};
    vecs[4]  = '{8'd5,  127,  -1,   1'b0};
    vecs[5]  = '{8'd10, 127,  127,  1'b0};
    vecs[6]  = '{8'd10, 127,  254,  1'b0};
    vecs[7]  = '{8'd10, 2,    0,    1'b1};
    vecs[8]  = '{8'd11, 127,  127,  1'b0};
    vecs[9]  = '{8'd11, 127,  254,  1'b0};
    vecs[10] = '{8'd11, 1,    255,  1'b0};
    vecs[11] = '{8'd9,  127,  127,  1'b0};
    vecs[12] = '{8'd9,  127,  254,  1'b0};
    vecs[13] = '{8'd3,  127,  127,  1'b0};
    vecs[14] = '{8'd3,  127,  254,  1'b0};

    ifm.clear_start = 1'b0; ifm.in_valid = 1'b0; ifm.in_addr = '0;
    ifm.in_weight = '0; ifm.spk_ready = 1'b1;
    hif.clear_start = 1'b0; hif.in_valid = 1'b0; hif.in_addr = '0;
    hif.in_weight = '0; hif.spk_ready = 1'b1;
    preset_m = 1'b1;

    #3;
    check("rst_clear_busy", int'(ifm.clear_busy), 0);
    check("rst_in_ready", int'(ifm.in_ready), 0);
    check("rst_spk_valid", int'(ifm.spk_valid), 0);
    check("rst_spk_addr", int'(ifm.spk_addr), 0);
    check("rst_rd_en", int'(ifm.rd_en), 0);
    check("rst_rd_addr", int'(ifm.rd_addr), 0);
    check("rst_wr_en", int'(ifm.wr_en), 0);
    check("rst_wr_addr", int'(ifm.wr_addr), 0);
    check("rst_wr_data", int'(ifm.wr_data), 0);

    @(posedge clk); #1;
    preset_m = 1'b0;
    reset_n  = 1'b1;
    @(negedge clk);
    check("idle_in_ready", int'(ifm.in_ready), 0);
    @(posedge clk); #1;
    check("run_in_ready", int'(ifm.in_ready), 1);

    // full-array clear on both instances
    ifm.clear_start = 1'b1;
    hif.clear_start = 1'b1;
    @(negedge clk);
    check("start_in_ready", int'(ifm.in_ready), 0);
    @(posedge clk); #1;
    ifm.clear_start = 1'b0;
    hif.clear_start = 1'b0;
    busy_cnt = 0;
    wr_seen  = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (ifm.clear_busy) begin
        busy_cnt++;
        if (ifm.wr_en) wr_seen++;
      end else begin
        break;
      end
    end
    check("sweep_busy_cycles", busy_cnt, 257);
    check("sweep_writes", wr_seen, 256);
    check("sweep_in_ready", int'(ifm.in_ready), 1);
    @(posedge clk); #1;
    nonzero = 0;
    for (int i = 0; i < 256; i++) if (mem_m[i] != 0) nonzero++;
    check("sweep_nonzero", nonzero, 0);

    for (int i = 0; i < 15; i++) send_m(vecs[i]);

    // back-to-back same-address events hit the forwarding path twice
    ifm.in_valid = 1'b1; ifm.in_addr = 8'd7; ifm.in_weight = 8'sd50;
    @(posedge clk); #1;
    ifm.in_weight = 8'sd50;
    @(negedge clk);
    check("haz_wr0", int'(ifm.wr_data), 50);
    @(posedge clk); #1;
    ifm.in_weight = -8'sd30;
    @(negedge clk);
    check("haz_wr1", int'(ifm.wr_data), 100);
    @(posedge clk); #1;
    ifm.in_valid = 1'b0;
    @(negedge clk);
    check("haz_wr2", int'(ifm.wr_data), 70);
    @(posedge clk); #1;
    check("haz_mem7", int'(mem_m[7]), 70);

    // spike backpressure: 3 fires, 9 fires behind it and stalls
    ifm.spk_ready = 1'b0;
    ifm.in_valid = 1'b1; ifm.in_addr = 8'd3; ifm.in_weight = 8'sd2;
    @(posedge clk); #1;
    ifm.in_addr = 8'd9; ifm.in_weight = 8'sd2;
    @(negedge clk);
    check("bp_in_ready0", int'(ifm.in_ready), 1);
    check("bp_wr3_data", int'(ifm.wr_data), 0);
    @(posedge clk); #1;
    ifm.in_addr = 8'd20; ifm.in_weight = 8'sd1;
    check("bp_spk3_valid", int'(ifm.spk_valid), 1);
    check("bp_spk3_addr", int'(ifm.spk_addr), 3);
    stall_miss = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (ifm.in_ready || ifm.wr_en || ifm.rd_en || ifm.spk_addr != 8'd3) stall_miss = 1'b1;
      @(posedge clk); #1;
    end
    check("bp_stall_held", int'(stall_miss), 0);
    ifm.spk_ready = 1'b1;
    @(negedge clk);
    check("bp_release_wr_en", int'(ifm.wr_en), 1);
    check("bp_release_wr_addr", int'(ifm.wr_addr), 9);
    check("bp_release_wr_data", int'(ifm.wr_data), 0);
    check("bp_release_in_ready", int'(ifm.in_ready), 1);
    @(posedge clk); #1;
    ifm.in_valid = 1'b0;
    check("bp_spk9_valid", int'(ifm.spk_valid), 1);
    check("bp_spk9_addr", int'(ifm.spk_addr), 9);
    @(negedge clk);
    check("bp_wr20_data", int'(ifm.wr_data), 1);
    @(posedge clk); #1;
    check("bp_spk_drop", int'(ifm.spk_valid), 0);
    check("bp_mem3", int'(mem_m[3]), 0);
    check("bp_mem9", int'(mem_m[9]), 0);
    check("bp_mem20", int'(mem_m[20]), 1);

    // overflow at the top of the charge range on the high-threshold instance
    stall_miss = 1'b0;
    hif.in_valid = 1'b1; hif.in_addr = 8'd1;
    for (int i = 0; i < 258; i++) begin
      hif.in_weight = (i == 257) ? 8'sd121 : 8'sd127;
      @(negedge clk);
      if (!hif.in_ready) stall_miss = 1'b1;
      @(posedge clk); #1;
    end
    hif.in_valid = 1'b0;
    @(posedge clk); #1;
    check("sat_stream_ready", int'(stall_miss), 0);
    check("sat_preset_mem1", int'(mem_h[1]), 32760);
    hif.in_valid = 1'b1; hif.in_weight = 8'sd100;
    @(posedge clk); #1;
    hif.in_valid = 1'b0;
    @(negedge clk);
`ifdef UCASPIAN_ACCUM_SAT_EN
    check("sat_wr_data", int'(hif.wr_data), 0);
`else
    check("sat_wr_data", int'(hif.wr_data), -32676);
`endif
    @(posedge clk); #1;
`ifdef UCASPIAN_ACCUM_SAT_EN
    check("sat_spk_valid", int'(hif.spk_valid), 1);
    check("sat_mem1", int'(mem_h[1]), 0);
`else
    check("sat_spk_valid", int'(hif.spk_valid), 0);
    check("sat_mem1", int'(mem_h[1]), -32676);
`endif

    // async reset in the middle of a sweep
    ifm.clear_start = 1'b1;
    @(posedge clk); #1;
    ifm.clear_start = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (ifm.clear_busy && ifm.wr_en && ifm.wr_addr == 8'd100) begin
        hit = 1'b1;
        break;
      end
    end
    check("mid_sweep_reached", int'(hit), 1);
    #2;
    reset_n = 1'b0;
    #1;
    snap = wr_cnt_m;
    check("abort_clear_busy", int'(ifm.clear_busy), 0);
    check("abort_wr_en", int'(ifm.wr_en), 0);
    check("abort_wr_addr", int'(ifm.wr_addr), 0);
    check("abort_in_ready", int'(ifm.in_ready), 0);
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(negedge clk);
    check("abort_idle_ready", int'(ifm.in_ready), 0);
    repeat (3) @(posedge clk);
    #1;
    check("abort_no_writes", wr_cnt_m, snap);
    check("abort_run_ready", int'(ifm.in_ready), 1);
    check("abort_not_busy", int'(ifm.clear_busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/charge_accum.md
Name: charge_accum

Overview:
- Read-modify-write front end for the 16x256 dual-port charge RAM.
- Accepts synaptic events (neuron address, signed weight) and reads the neuron's charge. Adds the weight and compares the result with a threshold.
- Writes back either the new charge or zero. A write of zero emits a spike event to the downstream fire queue.
- Also provides a full-array clear sweep for network reset between runs.

Parameters:
- ADDR_W, 8, neuron address width; RAM depth is 2**ADDR_W.
- DATA_W, 16, charge width, signed.
- WEIGHT_W, 8, synaptic weight width, signed.
- THRESHOLD, 16'sd256, fire when charge >= THRESHOLD (signed compare).

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- clear_start  in  1  pulse: start zeroing all RAM entries
- clear_busy  out  1  clear sweep in progress
- in_valid  in  1  event valid
- in_ready  out  1  event accepted when in_valid & in_ready
- in_addr  in  ADDR_W  target neuron
- in_weight  in  WEIGHT_W  signed weight
- spk_valid  out  1  spike event valid
- spk_ready  in  1  downstream accepts spike
- spk_addr  out  ADDR_W  neuron that fired
- rd_addr  out  ADDR_W  RAM read address
- rd_en  out  1  RAM read enable
- rd_data  in  DATA_W  RAM read data, valid 1 cycle after rd_en
- wr_addr  out  ADDR_W  RAM write address
- wr_en  out  1  RAM write enable
- wr_data  out  DATA_W  RAM write data

Behaviour:
- Reset: the following are 0 and the FSM is IDLE: clear_busy, in_ready, spk_valid, spk_addr, rd_en, wr_en, rd_addr, wr_addr, wr_data, stage-B valid, forward-valid.
- The RAM is read-before-write with 1-cycle synchronous read.
- FSM states:
  - IDLE: after reset; in_ready=0. Goes to RUN next cycle.
  - RUN: normal processing. On clear_start, stops accepting input and goes to DRAIN.
  - DRAIN: waits for stage B to empty, then goes to CLEAR.
  - CLEAR: writes 0 to address cnt, where cnt runs 0..2**ADDR_W-1, one entry per cycle. At the last address returns to RUN.
- clear_busy=1 in DRAIN and CLEAR. clear_start is ignored outside RUN.
- Stage A (RUN):
  - in_ready = !B_valid | B_done, where B_done = !fire | !spk_valid | spk_ready.
  - rd_addr=in_addr and rd_en=1 exactly on an accept edge.
  - Address and weight are registered into stage B.
- Stage B (cycle after accept):
  - base = fwd_hit ? fwd_data : rd_data.
  - fwd_hit = fwd_valid & fwd_addr==B_addr; fwd holds the write issued on the immediately preceding cycle. This covers the same-edge read/write hazard on back-to-back same-address events.
  - sum = base + sign-extended weight, computed at DATA_W+1 bits.
  - fire = sum >= THRESHOLD.
  - wr_addr=B_addr, wr_en=B_valid & B_done, wr_data = fire ? 0 : result.
  - When fire, spk_valid<=1 and spk_addr<=B_addr on the write edge.
- Stall:
  - If fire and spk_valid & !spk_ready, stage B holds, wr_en=0, rd_en=0 (RAM holds rd_data), in_ready=0.
  - fwd_valid clears after any cycle with wr_en=0.
- Throughput: 1 event/cycle when no spike backpressure.
- Latency: accept to write edge = 1 cycle. Accept to spk_valid = 2 edges.
- spk_valid drops on spk_valid & spk_ready unless a new fire loads the same edge.
- Async reset mid-sweep or mid-event aborts immediately; RAM contents are undefined-but-stable and must be re-cleared by the user.

Optional Feature:
- UCASPIAN_ACCUM_SAT_EN defined: the result saturates to [-2**(DATA_W-1), 2**(DATA_W-1)-1] before the threshold compare.
- Undefined: the result is the DATA_W-bit wrap of sum, and the compare uses the wrapped value.

Decomposition:
- Package ucaspian_pkg holds:
  - charge_t (logic signed [15:0]), weight_t (logic signed [7:0]), neuron_addr_t (logic [7:0]).
  - Default THRESHOLD constant.
  - accum_state_e enum {IDLE, RUN, DRAIN, CLEAR}.
- One natural sub-module: charge_sat_add (combinational base+weight, saturation under the macro, fire compare). Reused by later leak logic.

Test Plan:
- Sweep: clear_start after reset → clear_busy high for 256 cycles (+drain), all entries 0, then in_ready=1.
- Single accumulation: events (addr 5, +100) ×2 → RAM[5]=200, no spike. Third +100 → wr_data=0, spk_valid with spk_addr=5.
- Back-to-back hazard: events (7,+50),(7,+50),(7,-30) on consecutive cycles → RAM[7]=70, forwarding exercised twice.
- Backpressure: spk_ready=0, event fires on addr 3, then a second firing event on addr 9 → in_ready=0, wr_en=0 until spk_ready=1. Then spikes 3 then 9 in order, no event lost.
- Saturation: RAM[1]=32760 preset via weight stream, THRESHOLD raised to 32767, +100 → with macro RAM[1]=0 and spike; without macro wraps negative, no spike.
- Async reset mid-sweep at cnt=100 → outputs 0 immediately, FSM IDLE, no further writes.
